// File: rtl/ifu_lsu_axi_rd_arb.sv
// ifu_lsu_axi_rd_arb: round-robin AXI4 read arbiter sharing one master port between IFU (S0) and LSU (S1)
module ifu_lsu_axi_rd_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IDW = 2,
  parameter int MAX_OUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDW-1:0] s0_arid,
  input  logic [AW-1:0]  s0_araddr,
  input  logic [7:0]     s0_arlen,
  input  logic [2:0]     s0_arsize,
  input  logic [1:0]     s0_arburst,
  input  logic           s0_arvalid,
  output logic           s0_arready,
  output logic [IDW-1:0] s0_rid,
  output logic [DW-1:0]  s0_rdata,
  output logic [1:0]     s0_rresp,
  output logic           s0_rlast,
  output logic           s0_rvalid,
  input  logic           s0_rready,
  input  logic [IDW-1:0] s1_arid,
  input  logic [AW-1:0]  s1_araddr,
  input  logic [7:0]     s1_arlen,
  input  logic [2:0]     s1_arsize,
  input  logic [1:0]     s1_arburst,
  input  logic           s1_arvalid,
  output logic           s1_arready,
  output logic [IDW-1:0] s1_rid,
  output logic [DW-1:0]  s1_rdata,
  output logic [1:0]     s1_rresp,
  output logic           s1_rlast,
  output logic           s1_rvalid,
  input  logic           s1_rready,
  output logic [IDW:0]   m_arid,
  output logic [AW-1:0]  m_araddr,
  output logic [7:0]     m_arlen,
  output logic [2:0]     m_arsize,
  output logic [1:0]     m_arburst,
  output logic           m_arvalid,
  input  logic           m_arready,
  input  logic [IDW:0]   m_rid,
  input  logic [DW-1:0]  m_rdata,
  input  logic [1:0]     m_rresp,
  input  logic           m_rlast,
  input  logic           m_rvalid,
  output logic           m_rready,
  output logic           rsp_err_o
);
  localparam int CW = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state;
  logic rr_ptr;
  logic [CW-1:0] cnt0, cnt1;
  logic e0, e1, g1, hs, src, r_done, inc0, inc1, dec0, dec1;
  assign e0 = s0_arvalid & (cnt0 != CW'(MAX_OUT));
  assign e1 = s1_arvalid & (cnt1 != CW'(MAX_OUT));
  assign g1 = state == GNT1;
  assign m_arvalid = (state == GNT0) ? s0_arvalid : g1 ? s1_arvalid : 1'b0;
  assign m_arid = {g1, g1 ? s1_arid : s0_arid};
  assign m_araddr = g1 ? s1_araddr : s0_araddr;
  assign m_arlen = g1 ? s1_arlen : s0_arlen;
  assign m_arsize = g1 ? s1_arsize : s0_arsize;
  assign m_arburst = g1 ? s1_arburst : s0_arburst;
  assign s0_arready = (state == GNT0) & m_arready;
  assign s1_arready = g1 & m_arready;
  assign hs = m_arvalid & m_arready;
  assign inc0 = hs & ~g1;
  assign inc1 = hs & g1;
  assign src = m_rid[IDW];
  assign s0_rvalid = rst_n & m_rvalid & ~src;
  assign s1_rvalid = rst_n & m_rvalid & src;
  assign m_rready = rst_n & (src ? s1_rready : s0_rready);
  assign s0_rid = m_rid[IDW-1:0];
  assign s1_rid = m_rid[IDW-1:0];
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;
  assign r_done = m_rvalid & m_rready & m_rlast;
  assign dec0 = r_done & ~src;
  assign dec1 = r_done & src;
  // grant FSM, round-robin pointer, per-source outstanding counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      cnt0 <= '0;
      cnt1 <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (e0 | e1) state <= ((e0 & e1) ? rr_ptr : e1) ? GNT1 : GNT0;
      end else if (hs) begin
        state <= IDLE;
        rr_ptr <= ~g1;
      end else if (!m_arvalid) begin
        state <= IDLE;
      end
      cnt0 <= (inc0 & ~dec0) ? cnt0 + CW'(1) : (dec0 & ~inc0 & cnt0 != '0) ? cnt0 - CW'(1) : cnt0;
      cnt1 <= (inc1 & ~dec1) ? cnt1 + CW'(1) : (dec1 & ~inc1 & cnt1 != '0) ? cnt1 - CW'(1) : cnt1;
      rsp_err_o <= rsp_err_o | (dec0 & cnt0 == '0) | (dec1 & cnt1 == '0);
    end
  end
endmodule
